// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, DATA_W bits LSB-first, optional parity, 1-2 stops); start bit 1 cycle after accept.
// tx_ready = !hold_full: one word queues behind the running frame, so frames chain back-to-back with no idle gap.
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BCW-1:0]    baud_cnt;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] shift_dat;
    logic              par_bit;
    logic [DATA_W-1:0] hold_dat;
    logic              hold_vld;
    logic              accept;
    logic              baud_wrap;
    logic              load_in;
    logic              load_hold;
    logic              push_hold;

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return (PARITY_ODD != 0) ? ~^d : ^d;
    endfunction

    assign tx_ready  = !hold_vld;
    assign busy      = (state != IDLE);
    assign accept    = tx_valid && tx_ready;
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_in    = 1'b0;
        load_hold  = 1'b0;
        frame_done = 1'b0;
        serial_out = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_in   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                serial_out = 1'b0;
                if (baud_wrap) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                serial_out = shift_dat[0];
                if (baud_wrap && bit_cnt == DATA_LAST) begin
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                serial_out = par_bit;
                if (baud_wrap) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (baud_wrap && bit_cnt == STOP_LAST) begin
                    frame_done = 1'b1;
                    // A queued word wins over the live input, which sees tx_ready=0 anyway.
                    if (hold_vld) begin
                        load_hold = 1'b1;
                        state_nxt = START;
                    end else if (accept) begin
                        load_in   = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        push_hold = accept && (state != IDLE) && !load_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_dat <= '0;
            par_bit   <= 1'b0;
            hold_dat  <= '0;
            hold_vld  <= 1'b0;
        end else begin
            if (state == IDLE || baud_wrap) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BCW'(1);
            end

            // bit_cnt indexes data bits in DATA and stop bits in STOP; cleared on every state change.
            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if (baud_wrap && (state == DATA || state == STOP)) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (load_in) begin
                shift_dat <= tx_data;
                par_bit   <= parity_of(tx_data);
            end else if (load_hold) begin
                shift_dat <= hold_dat;
                par_bit   <= parity_of(hold_dat);
            end else if (state == DATA && baud_wrap) begin
                shift_dat <= shift_dat >> 1;
            end

            if (push_hold) begin
                hold_dat <= tx_data;
                hold_vld <= 1'b1;
            end else if (load_hold) begin
                hold_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (no parity / even parity / odd parity + 2 stops),
// per-instance expected-word queues drained by serial-line decoders.
module tb_uart_tx_param;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic       r0, r1, r2, s0, s1, s2, b0, b1, b2, f0, f1, f2;

    int cyc = 0;
    int assert_cnt = 0;
    int fail_cnt = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int         last_start[3];
    int         last_end[3];
    int         nframes[3];
    logic       last_par[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_valid(v0), .tx_data(d0), .tx_ready(r0),
        .serial_out(s0), .busy(b0), .frame_done(f0));
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1), .tx_ready(r1),
        .serial_out(s1), .busy(b1), .frame_done(f1));
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .tx_valid(v2), .tx_data(d2), .tx_ready(r2),
        .serial_out(s2), .busy(b2), .frame_done(f2));

    function automatic bit pe(input int k);    return (k != 0); endfunction
    function automatic bit podd(input int k);  return (k == 2); endfunction
    function automatic int nstop(input int k); return (k == 2) ? 2 : 1; endfunction

    function automatic logic get_ser(input int k);
        case (k) 0: return s0; 1: return s1; default: return s2; endcase
    endfunction
    function automatic logic get_rdy(input int k);
        case (k) 0: return r0; 1: return r1; default: return r2; endcase
    endfunction
    function automatic logic get_busy(input int k);
        case (k) 0: return b0; 1: return b1; default: return b2; endcase
    endfunction
    function automatic logic get_fd(input int k);
        case (k) 0: return f0; 1: return f1; default: return f2; endcase
    endfunction

    function automatic void q_push(input int k, input logic [7:0] w);
        case (k) 0: q0.push_back(w); 1: q1.push_back(w); default: q2.push_back(w); endcase
    endfunction
    function automatic int q_size(input int k);
        case (k) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
    endfunction
    function automatic logic [7:0] q_pop(input int k);
        if (q_size(k) == 0) return 8'h00;
        case (k) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
    endfunction
    function automatic void q_clear(input int k);
        case (k) 0: q0.delete(); 1: q1.delete(); default: q2.delete(); endcase
    endfunction

    task automatic drive(input int k, input logic v, input logic [7:0] w);
        case (k)
            0: begin v0 = v; d0 = w; end
            1: begin v1 = v; d1 = w; end
            default: begin v2 = v; d2 = w; end
        endcase
    endtask

    // Decodes frames on one serial line and compares them cycle by cycle against the queued word.
    task automatic monitor(input int k);
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && get_ser(k) === 1'b0) begin
                logic [15:0] bits;
                logic [7:0]  w;
                logic [7:0]  dec;
                logic        par;
                int          nb, t0, bit_err, fd_err, busy_err;
                bit          ab, have;
                have = (q_size(k) != 0);
                w = q_pop(k);
                assert_cnt++;
                if (!have) begin
                    fail_cnt++;
                    $display("FAIL unexpected_frame dut%0d: queued words=0 required>=1", k);
                end
                bits = '0;
                for (int i = 0; i < 8; i++) bits[1+i] = w[i];
                nb = 9;
                if (pe(k)) begin
                    bits[nb] = podd(k) ? ~^w : ^w;
                    nb++;
                end
                for (int s = 0; s < nstop(k); s++) begin
                    bits[nb] = 1'b1;
                    nb++;
                end
                t0 = cyc; ab = 0; dec = '0; par = 1'b0;
                bit_err = 0; fd_err = 0; busy_err = 0;
                for (int b = 0; b < nb && !ab; b++) begin
                    for (int c = 0; c < CPB && !ab; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst !== 1'b0) begin
                            ab = 1;
                        end else begin
                            if (get_ser(k) !== bits[b]) bit_err++;
                            if (get_fd(k) !== ((b == nb - 1) && (c == CPB - 1))) fd_err++;
                            if (get_busy(k) !== 1'b1) busy_err++;
                            if (c == CPB / 2) begin
                                if (b >= 1 && b <= 8) dec[b-1] = get_ser(k);
                                if (pe(k) && b == 9) par = get_ser(k);
                            end
                        end
                    end
                end
                if (ab) begin
                    q_clear(k);
                end else begin
                    assert_cnt += 4;
                    if (dec !== w) begin
                        fail_cnt++;
                        $display("FAIL frame_data dut%0d: got %02h required %02h", k, dec, w);
                    end
                    if (bit_err !== 0) begin
                        fail_cnt++;
                        $display("FAIL frame_wave dut%0d word %02h: %0d bad cycles required 0", k, w, bit_err);
                    end
                    if (fd_err !== 0) begin
                        fail_cnt++;
                        $display("FAIL frame_done_pulse dut%0d: %0d bad cycles required 0", k, fd_err);
                    end
                    if (busy_err !== 0) begin
                        fail_cnt++;
                        $display("FAIL busy_in_frame dut%0d: %0d low cycles required 0", k, busy_err);
                    end
                    last_start[k] = t0;
                    last_end[k]   = cyc;
                    last_par[k]   = par;
                    nframes[k]++;
                end
            end
        end
    endtask

    task automatic send(input int k, input logic [7:0] w, output int acc);
        int n = 0;
        drive(k, 1'b1, w);
        while (get_rdy(k) !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        assert_cnt++;
        if (get_rdy(k) !== 1'b1) begin
            fail_cnt++;
            $display("FAIL send_timeout dut%0d word %02h: tx_ready=%b required 1", k, w, get_rdy(k));
            drive(k, 1'b0, 8'h00);
            acc = -1;
        end else begin
            q_push(k, w);
            @(posedge clk);
            #1;
            acc = cyc;
            drive(k, 1'b0, 8'h00);
        end
    endtask

    task automatic wait_frames(input int k, input int target, input string name);
        int n = 0;
        while (nframes[k] < target && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        assert_cnt++;
        if (nframes[k] < target) begin
            fail_cnt++;
            $display("FAIL %s_timeout dut%0d: frames=%0d required=%0d", name, k, nframes[k], target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            assert_cnt += 4;
            if (get_ser(k) !== 1'b1) begin fail_cnt++; $display("FAIL reset_serial dut%0d: %b required 1", k, get_ser(k)); end
            if (get_rdy(k) !== 1'b1) begin fail_cnt++; $display("FAIL reset_ready dut%0d: %b required 1", k, get_rdy(k)); end
            if (get_busy(k) !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy dut%0d: %b required 0", k, get_busy(k)); end
            if (get_fd(k) !== 1'b0) begin fail_cnt++; $display("FAIL reset_frame_done dut%0d: %b required 0", k, get_fd(k)); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int acc, nf;
        nf = nframes[0];
        @(negedge clk);
        send(0, 8'hA5, acc);
        wait_frames(0, nf + 1, "basic");
        assert_cnt += 2;
        if (last_start[0] !== acc) begin fail_cnt++; $display("FAIL basic_latency: start cyc %0d required %0d", last_start[0], acc); end
        if (last_end[0] - last_start[0] + 1 !== 40) begin fail_cnt++; $display("FAIL basic_length: %0d required 40", last_end[0] - last_start[0] + 1); end
        @(negedge clk);
        assert_cnt += 3;
        if (b0 !== 1'b0) begin fail_cnt++; $display("FAIL basic_busy_fall: %b required 0", b0); end
        if (f0 !== 1'b0) begin fail_cnt++; $display("FAIL basic_fd_after: %b required 0", f0); end
        if (s0 !== 1'b1) begin fail_cnt++; $display("FAIL basic_idle_line: %b required 1", s0); end
    endtask

    task automatic test_parity();
        int acc, nf;
        nf = nframes[1];
        @(negedge clk);
        send(1, 8'hA5, acc);
        wait_frames(1, nf + 1, "parity_even");
        assert_cnt += 2;
        if (last_end[1] - last_start[1] + 1 !== 44) begin fail_cnt++; $display("FAIL parity_even_length: %0d required 44", last_end[1] - last_start[1] + 1); end
        if (last_par[1] !== 1'b0) begin fail_cnt++; $display("FAIL parity_even_bit: %b required 0", last_par[1]); end
        nf = nframes[2];
        @(negedge clk);
        send(2, 8'hA5, acc);
        wait_frames(2, nf + 1, "parity_odd");
        assert_cnt += 2;
        if (last_end[2] - last_start[2] + 1 !== 48) begin fail_cnt++; $display("FAIL parity_odd_length: %0d required 48", last_end[2] - last_start[2] + 1); end
        if (last_par[2] !== 1'b1) begin fail_cnt++; $display("FAIL parity_odd_bit: %b required 1", last_par[2]); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, nf, e1;
        nf = nframes[0];
        @(negedge clk);
        send(0, 8'h55, a1);
        send(0, 8'h0F, a2);
        assert_cnt += 2;
        if (a2 !== a1 + 1) begin fail_cnt++; $display("FAIL b2b_accept_busy: cyc %0d required %0d", a2, a1 + 1); end
        if (r0 !== 1'b0) begin fail_cnt++; $display("FAIL b2b_ready_drop: %b required 0", r0); end
        wait_frames(0, nf + 1, "b2b_first");
        e1 = last_end[0];
        @(posedge clk);
        #1;
        assert_cnt++;
        if (r0 !== 1'b1) begin fail_cnt++; $display("FAIL b2b_ready_return: %b required 1", r0); end
        wait_frames(0, nf + 2, "b2b_second");
        assert_cnt++;
        if (last_start[0] !== e1 + 1) begin fail_cnt++; $display("FAIL b2b_no_gap: start %0d required %0d", last_start[0], e1 + 1); end
    endtask

    task automatic test_hold_full();
        int a1, a2, a3, nf, e1;
        nf = nframes[0];
        @(negedge clk);
        send(0, 8'h55, a1);
        send(0, 8'h0F, a2);
        send(0, 8'h3C, a3);
        e1 = last_end[0];
        assert_cnt++;
        if (a3 !== e1 + 2) begin fail_cnt++; $display("FAIL hold_third_accept: cyc %0d required %0d", a3, e1 + 2); end
        wait_frames(0, nf + 3, "hold_full");
        assert_cnt++;
        if (last_end[0] - a1 + 1 !== 120) begin fail_cnt++; $display("FAIL hold_total_span: %0d required 120", last_end[0] - a1 + 1); end
    endtask

    task automatic test_two_stop();
        int a1, a2, nf;
        nf = nframes[2];
        @(negedge clk);
        send(2, 8'h96, a1);
        send(2, 8'h3C, a2);
        wait_frames(2, nf + 2, "two_stop");
        assert_cnt += 2;
        if (last_end[2] - a1 + 1 !== 96) begin fail_cnt++; $display("FAIL two_stop_span: %0d required 96", last_end[2] - a1 + 1); end
        if (last_start[2] !== a1 + 48) begin fail_cnt++; $display("FAIL two_stop_next_start: %0d required %0d", last_start[2], a1 + 48); end
    endtask

    task automatic test_reset_mid();
        int a1, a2, nf, zeros;
        nf = nframes[0];
        @(negedge clk);
        send(0, 8'h55, a1);
        send(0, 8'h0F, a2);
        while (cyc < a1 + 16) @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        assert_cnt += 3;
        if (s0 !== 1'b1) begin fail_cnt++; $display("FAIL rst_mid_serial: %b required 1", s0); end
        if (b0 !== 1'b0) begin fail_cnt++; $display("FAIL rst_mid_busy: %b required 0", b0); end
        if (r0 !== 1'b1) begin fail_cnt++; $display("FAIL rst_mid_ready: %b required 1", r0); end
        @(negedge clk);
        #1;
        rst = 1'b0;
        zeros = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (s0 !== 1'b1) zeros++;
        end
        assert_cnt += 2;
        if (zeros !== 0) begin fail_cnt++; $display("FAIL rst_mid_line_quiet: %0d low cycles required 0", zeros); end
        if (nframes[0] !== nf) begin fail_cnt++; $display("FAIL rst_mid_no_frame: frames %0d required %0d", nframes[0], nf); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            nframes[k] = 0;
            last_start[k] = 0;
            last_end[k] = 0;
            last_par[k] = 1'b0;
        end
        test_reset();
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        test_basic();
        test_parity();
        test_back_to_back();
        test_hold_full();
        test_two_stop();
        test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            assert_cnt++;
            if (q_size(k) !== 0) begin fail_cnt++; $display("FAIL scoreboard_drain dut%0d: %0d left required 0", k, q_size(k)); end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
